// File: rtl/crc_serial_gen.sv
// Serial LFSR CRC generator: absorbs DATA while ACTIVE, then shifts the CRC out LSB first.
// Define CRC_SERIAL_GEN_PARALLEL_OUT_EN to add the parallel CRC_WORD output.
module crc_serial_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h44,
  parameter logic [WIDTH-1:0] SEED  = 8'hD8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ACTIVE,
  input  logic             DATA,
  output logic             CRC,
  output logic             Valid,
`ifdef CRC_SERIAL_GEN_PARALLEL_OUT_EN
  output logic [WIDTH-1:0] CRC_WORD,
`endif
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [WIDTH-1:0] TAPS = {1'b0, POLY[WIDTH-2:0]};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             crc_q, crc_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
`ifdef CRC_SERIAL_GEN_PARALLEL_OUT_EN
  logic [WIDTH-1:0] word_q, word_d;
`endif

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] l,
    input logic             d
  );
    logic fb;
    fb = l[0] ^ d;
    return {fb, l[WIDTH-1:1]} ^ (TAPS & {WIDTH{fb}});
  endfunction

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    crc_d   = 1'b0;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef CRC_SERIAL_GEN_PARALLEL_OUT_EN
    word_d  = word_q;
`endif
    unique case (state_q)
      IDLE: begin
        lfsr_d = SEED;
        cnt_d  = '0;
        if (ACTIVE) begin
          lfsr_d  = step(SEED, DATA);
          state_d = CALC;
`ifdef CRC_SERIAL_GEN_PARALLEL_OUT_EN
          word_d  = '0;
`endif
        end
      end
      CALC: begin
        if (ACTIVE) begin
          lfsr_d = step(lfsr_q, DATA);
        end else begin
          crc_d   = lfsr_q[0];
          valid_d = 1'b1;
          lfsr_d  = lfsr_q >> 1;
          cnt_d   = CW'(1);
          state_d = OUT;
`ifdef CRC_SERIAL_GEN_PARALLEL_OUT_EN
          word_d  = lfsr_q;
`endif
        end
      end
      OUT: begin
        // A finished frame takes priority over a late ACTIVE.
        if (cnt_q == CNT_MAX) begin
          done_d  = 1'b1;
          lfsr_d  = SEED;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (ACTIVE) begin
          lfsr_d  = step(SEED, DATA);
          cnt_d   = '0;
          state_d = CALC;
`ifdef CRC_SERIAL_GEN_PARALLEL_OUT_EN
          word_d  = '0;
`endif
        end else begin
          crc_d   = lfsr_q[0];
          valid_d = 1'b1;
          lfsr_d  = lfsr_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        lfsr_d  = SEED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      crc_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef CRC_SERIAL_GEN_PARALLEL_OUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) word_q <= '0;
    else     word_q <= word_d;
  end

  assign CRC_WORD = word_q;
`endif

  assign CRC   = crc_q;
  assign Valid = valid_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_crc_serial_gen.sv
// Scoreboard bench for crc_serial_gen: an 8-bit default instance and a
// 16-bit CCITT-style instance share the same random message stream.
module tb_crc_serial_gen;

  logic CLK, RST, ACTIVE, DATA;
  logic crc8, v8, d8;
  logic crc16, v16, d16;

  typedef struct {
    bit is_done;
    bit b;
  } ev_t;

  ev_t q[2][$];
  int  compared = 0;
  int  mismatched = 0;
  int  wid[2] = '{8, 16};
  bit  mv[2], md[2], mc[2];

  crc_serial_gen u8 (
    .CLK(CLK), .RST(RST), .ACTIVE(ACTIVE), .DATA(DATA),
    .CRC(crc8), .Valid(v8), .Done(d8)
  );

  crc_serial_gen #(
    .WIDTH(16), .POLY(16'h1021), .SEED(16'hFFFF)
  ) u16 (
    .CLK(CLK), .RST(RST), .ACTIVE(ACTIVE), .DATA(DATA),
    .CRC(crc16), .Valid(v16), .Done(d16)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Galois-form LFSR over the whole message.
  function automatic logic [31:0] crc_model(
    input int w, input logic [31:0] poly,
    input logic [31:0] seed, input bit m[$]
  );
    logic [31:0] l, top, taps;
    top  = 32'h1 << (w - 1);
    taps = (poly & (top - 32'h1)) | top;
    l = seed;
    foreach (m[i]) begin
      if (l[0] ^ m[i]) l = (l >> 1) ^ taps;
      else             l = l >> 1;
    end
    return l;
  endfunction

  task automatic chk(input string nm, input logic got, input logic exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_crc8"}, crc8, 1'b0);
    chk({nm, "_valid8"}, v8, 1'b0);
    chk({nm, "_done8"}, d8, 1'b0);
    chk({nm, "_crc16"}, crc16, 1'b0);
    chk({nm, "_valid16"}, v16, 1'b0);
    chk({nm, "_done16"}, d16, 1'b0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // cut=0: full frame; cut>0: interrupted after cut CRC bits
  task automatic frame(
    input bit m[$], input int cut, input bit use_rst,
    input bit use_force, input logic [31:0] f8
  );
    logic [31:0] r[2];
    ev_t e;
    int nb;
    r[0] = use_force ? f8 : crc_model(8, 32'h44, 32'hD8, m);
    r[1] = crc_model(16, 32'h1021, 32'hFFFF, m);
    foreach (m[i]) begin
      ACTIVE = 1'b1;
      DATA   = m[i];
      step();
    end
    ACTIVE = 1'b0;
    DATA   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nb = (cut == 0) ? wid[k] : cut;
      for (int b = 0; b < nb; b++) begin
        e.is_done = 1'b0;
        e.b = r[k][b];
        q[k].push_back(e);
      end
      if (cut == 0) begin
        e.is_done = 1'b1;
        e.b = 1'b0;
        q[k].push_back(e);
      end
    end
    if (cut == 0) begin
      repeat (20) step();
    end else begin
      repeat (cut) step();
      if (use_rst) begin
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk_zero("rst_mid_out");
        step();
        RST = 1'b0;
      end
    end
  endtask

  task automatic rand_frame(input int n, input int cut, input bit use_rst);
    bit m[$];
    for (int i = 0; i < n; i++) m.push_back(1'($urandom_range(0, 1)));
    frame(m, cut, use_rst, 1'b0, 32'h0);
  endtask

  always @(negedge CLK) begin
    ev_t e;
    mv[0] = v8;  md[0] = d8;  mc[0] = crc8;
    mv[1] = v16; md[1] = d16; mc[1] = crc16;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (mv[k] && md[k]) begin
        mismatched++;
        $display("FAIL valid_and_done dut%0d: both high, required exclusive", k);
      end
      if (mv[k] || md[k]) begin
        compared++;
        if (q[k].size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_out dut%0d: valid=%b done=%b, none expected",
                   k, mv[k], md[k]);
        end else begin
          e = q[k].pop_front();
          if (e.is_done != md[k] || (!e.is_done && e.b != mc[k])) begin
            mismatched++;
            $display("FAIL serial dut%0d: got v=%b d=%b crc=%b expected d=%b crc=%b",
                     k, mv[k], md[k], mc[k], e.is_done, e.b);
          end
        end
      end else begin
        compared++;
        if (mc[k] !== 1'b0) begin
          mismatched++;
          $display("FAIL crc_idle dut%0d: got %b expected 0", k, mc[k]);
        end
      end
    end
  end

  initial begin
    bit m[$];
    RST = 1'b1;
    ACTIVE = 1'b0;
    DATA = 1'b0;
    #2;
    chk_zero("reset");
    step();
    step();
    RST = 1'b0;
    repeat (100) step();

    m = {1'b0};
    frame(m, 0, 1'b0, 1'b1, 32'h6C);
    m = {1'b1};
    frame(m, 0, 1'b0, 1'b1, 32'hA8);

    rand_frame(5, 3, 1'b0);
    rand_frame(64, 0, 1'b0);
    rand_frame(20, 4, 1'b1);
    rand_frame(64, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      int mode, n;
      mode = $urandom_range(0, 2);
      n = $urandom_range(1, 64);
      if (mode == 0) begin
        rand_frame(n, 0, 1'b0);
      end else begin
        rand_frame(n, $urandom_range(1, 7), mode == 2);
        rand_frame($urandom_range(1, 64), 0, 1'b0);
      end
    end

    repeat (5) step();
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (q[k].size() != 0) begin
        mismatched++;
        $display("FAIL queue_drain dut%0d: got %0d left expected 0",
                 k, q[k].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
